data_memory_unit: RTL and testbench
===================================

# data_memory_unit

Parametrised, clocked load/store data memory for the single-cycle/multicycle CPU datapath. Replaces the combinational word-only store/load block. Adds:

- byte, halfword and word accesses with sign/zero extension;
- base + signed-offset addressing with alignment and range checks;
- a valid/ready request/response handshake;
- a hardware clear sweep after reset.

It sits between the execute stage (address/data source) and write-back (load result sink).

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, at least 4.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset via sweep; 0 = contents retained across reset.
- Derived constant IDX_W = clog2(DEPTH).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_base  in  32  base byte address.
- req_offset  in  16  signed byte offset.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load result (extended); 0 for stores and errors.
- rsp_error  out  1  misaligned, out-of-range or reserved size.

## Operation
Address and checks:
- Effective address: ea = req_base + sext(req_offset), computed mod 2^32.
- Word index = ea[IDX_W+1:2].
- Error conditions:
  - req_size == 3;
  - half with ea[0] != 0;
  - word with ea[1:0] != 0;
  - ea >= 4*DEPTH.
- An errored request is still accepted. It performs no write and returns rsp_error = 1, rsp_rdata = 0.

Stores:
- Byte lane = ea[1:0]; half lanes = {ea[1],1} and {ea[1],0}; word = all four lanes.
- Only the selected lanes are modified.
- Data is taken from req_wdata[7:0], [15:0] or [31:0].

Loads:
- The selected lane(s) are shifted to bit 0.
- Sign- or zero-extended per req_unsigned (ignored for word).

States:
- CLEAR:
  - Writes 0 to word clr_ptr and increments clr_ptr each cycle.
  - After writing DEPTH-1, goes to RUN.
  - req_ready = 0 throughout.
- RUN: normal operation.

Handshake:
- req_ready = (state == RUN) && (!rsp_valid || rsp_ready).
- A request is accepted when req_valid && req_ready.

## Timing
Reset values (edge with reset = 1):
- rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, clr_ptr = 0.
- State = CLEAR if CLEAR_ON_RESET, else RUN.
- req_ready = 0 while reset is held.

Clear sweep:
- Occupies exactly DEPTH edges after reset falls.
- req_ready first goes high DEPTH cycles after the first non-reset edge.

Accepted requests:
- A store's write commits on the accept edge.
- rsp_valid rises on the accept edge (1-cycle latency).
- The response holds stable until the edge where rsp_valid && rsp_ready.

Back-to-back and ordering:
- Accept plus response pop in the same cycle: the new response replaces the old one. This gives full throughput of 1 request/cycle.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. No stale read.

Reset mid-operation:
- The pending response is dropped (rsp_valid = 0 next edge).
- A store already accepted stays written unless the clear sweep overwrites it.
- Reset during CLEAR restarts the sweep at 0.

## Structure
- Package dmem_pkg:
  - size encodings SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_RSVD = 2'd3;
  - state enum {CLEAR, RUN};
  - error-check function.
- Sub-module dmem_byte_lane (combinational):
  - inputs: size, ea[1:0], unsigned flag, old word, wdata;
  - outputs: byte-enable mask, merged write word, extended load data.
- Top module holds the memory array, FSM, clr_ptr and response register.

## Test plan
- Reset, DEPTH = 16, CLEAR_ON_RESET = 1:
  - req_ready is 0 for 16 cycles after reset falls, then 1.
  - Word loads of all 16 addresses return 0.
- Store word 0x8081_7F01 at base = 0x20, offset = -4 (ea = 0x1C), then byte loads at 0x1C..0x1F:
  - signed: 0x00000001, 0x0000007F, 0xFFFFFF81, 0xFFFFFF80;
  - unsigned byte at 0x1F: 0x00000080.
- Store half 0xBEEF at ea = 0x12 over word 0x11223344 at 0x10:
  - word load at 0x10 returns 0xBEEF3344;
  - signed half load at 0x12 returns 0xFFFFBEEF.
- Word store at ea = 0x06, half load at ea = 0x03, size = 3, and word load at ea = 4*DEPTH:
  - each returns rsp_error = 1, rsp_rdata = 0;
  - memory is unchanged.
- Back-to-back traffic with rsp_ready held 0 for 3 cycles:
  - req_ready = 0 during the stall;
  - the first response holds stable;
  - after release, 1 request/cycle throughput.
  - Store 5 to 0x0 then load 0x0 on the next cycle returns 5.
- Assert reset mid-stream with a response pending:
  - rsp_valid = 0 after the next edge;
  - the sweep restarts;
  - with CLEAR_ON_RESET = 0, previously stored words read back unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory unit.
//   - access size encodings carried on req_size
//   - FSM state type (CLEAR sweep / RUN)
//   - access_error(): decides whether a request is rejected
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // A request errors on a reserved size, a misaligned half/word, or an
    // effective address beyond the end of the array (limit = bytes in array).
    function automatic logic access_error(input logic [1:0]  size,
                                          input logic [31:0] ea,
                                          input logic [31:0] limit);
        logic err;
        err = (ea >= limit);
        case (size)
            SZ_HALF: err = err | ea[0];
            SZ_WORD: err = err | (|ea[1:0]);
            SZ_RSVD: err = 1'b1;
            default: ;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Combinational lane steering for one 32-bit memory word.
//   size      : access size (SZ_*)
//   ea_lo     : ea[1:0], selects the byte / half lanes
//   is_unsigned : loads zero-extend when 1, sign-extend when 0
//   old_word  : current contents of the addressed word
//   wdata     : right-justified store data
//   be        : byte-enable mask of the lanes touched by this access
//   wr_word   : old_word with the enabled lanes replaced by store data
//   rd_data   : selected lane(s) moved to bit 0 and extended
module dmem_byte_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  ea_lo,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data
);

    logic [31:0] src;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be      = 4'b0000;
        src     = wdata;
        rd_data = '0;
        byte_v  = old_word[{ea_lo, 3'b000} +: 8];
        half_v  = ea_lo[1] ? old_word[31:16] : old_word[15:0];
        case (size)
            SZ_BYTE: begin
                be      = 4'b0001 << ea_lo;
                // Replicate so whichever lane is enabled sees the right byte.
                src     = {4{wdata[7:0]}};
                rd_data = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                be      = ea_lo[1] ? 4'b1100 : 4'b0011;
                src     = {2{wdata[15:0]}};
                rd_data = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            SZ_WORD: begin
                be      = 4'b1111;
                src     = wdata;
                rd_data = old_word;
            end
            default: ;
        endcase

        wr_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wr_word[8*i +: 8] = src[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_memory_unit.sv
// Clocked load/store data memory with byte/half/word access, base+offset
// addressing, range/alignment checks and a post-reset clear sweep.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   req_valid / req_ready   : request handshake
//   req_store, req_size, req_unsigned, req_base, req_offset, req_wdata
//                           : request fields
//   rsp_valid / rsp_ready   : response handshake
//   rsp_rdata, rsp_error    : response fields (rdata is 0 for stores/errors)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds valid and payload stable until then, and
// ready never depends on the same-side valid.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_base,
    input  logic [15:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);
    localparam state_t      INIT_ST   = CLEAR_ON_RESET ? CLEAR : RUN;

    logic [31:0] mem [DEPTH];

    state_t           state, state_next;
    logic [IDX_W-1:0] clr_ptr;

    logic [31:0]      ea;
    logic [IDX_W-1:0] idx;
    logic             err;
    logic             accept;
    logic             wr_en;
    logic [3:0]       be;
    logic [31:0]      wr_word;
    logic [31:0]      rd_data;

    assign ea     = req_base + {{16{req_offset[15]}}, req_offset};
    assign idx    = ea[IDX_W+1:2];
    assign err    = access_error(req_size, ea, MEM_BYTES);
    assign accept = req_valid && req_ready;
    assign wr_en  = accept && req_store && !err && (|be);

    dmem_byte_lane u_lane (
        .size        (req_size),
        .ea_lo       (ea[1:0]),
        .is_unsigned (req_unsigned),
        .old_word    (mem[idx]),
        .wdata       (req_wdata),
        .be          (be),
        .wr_word     (wr_word),
        .rd_data     (rd_data)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= INIT_ST;
        else       state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            CLEAR: if (clr_ptr == IDX_W'(DEPTH - 1)) state_next = RUN;
            RUN:   ;
            default: state_next = RUN;
        endcase
    end

    // FSM: outputs. A pending response blocks new requests unless it is
    // being popped this same cycle, which keeps 1 request/cycle throughput.
    always_comb begin
        req_ready = 1'b0;
        if (!reset && state == RUN && (!rsp_valid || rsp_ready)) req_ready = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)               clr_ptr <= '0;
        else if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
    end

    // Memory writes: the sweep owns the array while in CLEAR; otherwise
    // stores commit on their accept edge so the next load sees them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) mem[clr_ptr] <= '0;
            else if (wr_en)     mem[idx]     <= wr_word;
        end
    end

    // Response register
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_error <= err;
            rsp_rdata <= (err || req_store) ? 32'd0 : rd_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;

    localparam int DEPTH = 16;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid, req_store, req_unsigned, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_base, req_wdata;
    logic [15:0] req_offset;

    logic        v0, v1, rdy0, rdy1, rv0, rv1, re0, re1;
    logic [31:0] rd0, rd1;
    logic        req_ready_m, rsp_valid_m, rsp_error_m;
    logic [31:0] rsp_rdata_m;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_mode;

    logic [32:0] exp_q[$];
    logic [7:0]  bmem0 [NBYTES];
    logic [7:0]  bmem1 [NBYTES];

    assign v0 = req_valid & ~sel;
    assign v1 = req_valid & sel;
    assign req_ready_m = sel ? rdy1 : rdy0;
    assign rsp_valid_m = sel ? rv1 : rv0;
    assign rsp_error_m = sel ? re1 : re0;
    assign rsp_rdata_m = sel ? rd1 : rd0;

    data_memory_unit #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0),
        .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_error(re0)
    );

    data_memory_unit #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0)) u_dut_keep (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
        .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_error(re1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response-side backpressure: 0 = always ready, 1 = random, 2 = stalled.
    always @(negedge clk) begin
        case (ready_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 3) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte-addressed little-endian memory.
    task automatic model_req(input logic st, input logic [1:0] sz, input logic uns,
                             input logic [31:0] base, input logic [15:0] off,
                             input logic [31:0] wd, output logic [32:0] rsp);
        logic [31:0] ea;
        logic [31:0] v;
        int          n;
        logic        e;
        ea = base + {{16{off[15]}}, off};
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e  = (sz == 2'd3) || ((ea % n) != 0) || (ea >= NBYTES);
        v  = 32'd0;
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                if (st) begin
                    if (sel) bmem1[int'(ea) + i] = wd[8*i +: 8];
                    else     bmem0[int'(ea) + i] = wd[8*i +: 8];
                end else begin
                    v[8*i +: 8] = sel ? bmem1[int'(ea) + i] : bmem0[int'(ea) + i];
                end
            end
            if (!st && !uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            if (st) v = 32'd0;
        end
        rsp = {e, v};
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] base, input logic [15:0] off, input logic [31:0] wd);
        logic        acc;
        logic [32:0] r;
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
        req_base = base; req_offset = off; req_wdata = wd;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            #4;
            acc = req_ready_m;
            @(posedge clk);
            if (acc) begin
                model_req(st, sz, uns, base, off, wd, r);
                exp_q.push_back(r);
            end
            @(negedge clk);
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: actual=no accept required=accept within 200 cycles");
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        ready_mode = 0;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
            @(negedge clk); #5;
        end
        @(negedge clk);
        chk("drain_empty", 34'(exp_q.size()), 34'd0);
        exp_q.delete();
    endtask

    // From a negedge right after reset falls: ready low for DEPTH cycles, then high.
    task automatic sweep_check();
        for (int k = 0; k <= DEPTH; k++) begin
            #4;
            chk($sformatf("sweep_ready_%0d", k), {33'd0, rdy0}, {33'd0, (k == DEPTH)});
            @(negedge clk);
        end
        for (int i = 0; i < NBYTES; i++) bmem0[i] = 8'h00;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic        hold_p = 1'b0;
    logic [32:0] hold_v;
    always begin
        logic [32:0] e;
        @(negedge clk); #3;
        if (reset) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p)
                chk("rsp_hold", {rsp_valid_m, rsp_error_m, rsp_rdata_m}, {1'b1, hold_v});
            if (rsp_valid_m && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: actual=0x%0h required=no response", rsp_rdata_m);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", {1'b0, rsp_error_m, rsp_rdata_m}, {1'b0, e});
                end
                hold_p = 1'b0;
            end else if (rsp_valid_m) begin
                hold_p = 1'b1;
                hold_v = {rsp_error_m, rsp_rdata_m};
            end else begin
                hold_p = 1'b0;
            end
        end
    end

    // ---------------- main stimulus ----------------
    logic [31:0] keep_data [6];
    int          c0;

    initial begin
        sel = 1'b0; ready_mode = 0; rsp_ready = 1'b1; reset = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_base = '0; req_offset = '0; req_wdata = '0;
        for (int i = 0; i < NBYTES; i++) begin bmem0[i] = 8'h00; bmem1[i] = 8'h00; end

        repeat (3) @(posedge clk);
        @(negedge clk); #4;
        chk("reset_rsp", {rv0, re0, rd0}, 34'd0);
        chk("reset_ready0", {33'd0, rdy0}, 34'd0);
        chk("reset_ready1", {33'd0, rdy1}, 34'd0);
        @(negedge clk);
        reset = 1'b0;
        sweep_check();

        // cleared contents
        for (int i = 0; i < DEPTH; i++) send(1'b0, 2'd2, 1'b0, 32'(4*i), 16'd0, 32'd0);
        idle(); drain();

        // byte extraction with negative offset
        send(1'b1, 2'd2, 1'b0, 32'h20, 16'hFFFC, 32'h8081_7F01);
        for (int i = 0; i < 4; i++) send(1'b0, 2'd0, 1'b0, 32'h1C + 32'(i), 16'd0, 32'd0);
        send(1'b0, 2'd0, 1'b1, 32'h1F, 16'd0, 32'd0);
        // half merge
        send(1'b1, 2'd2, 1'b0, 32'h10, 16'd0, 32'h1122_3344);
        send(1'b1, 2'd1, 1'b0, 32'h12, 16'd0, 32'h0000_BEEF);
        send(1'b0, 2'd2, 1'b0, 32'h10, 16'd0, 32'd0);
        send(1'b0, 2'd1, 1'b0, 32'h12, 16'd0, 32'd0);
        send(1'b0, 2'd1, 1'b1, 32'h10, 16'd2, 32'd0);
        // errors, then confirm memory untouched
        send(1'b1, 2'd2, 1'b0, 32'h06, 16'd0, 32'hDEAD_BEEF);
        send(1'b0, 2'd1, 1'b0, 32'h03, 16'd0, 32'd0);
        send(1'b1, 2'd3, 1'b0, 32'h08, 16'd0, 32'h1234_5678);
        send(1'b0, 2'd2, 1'b0, 32'(NBYTES), 16'd0, 32'd0);
        send(1'b0, 2'd2, 1'b0, 32'h04, 16'd0, 32'd0);
        send(1'b0, 2'd2, 1'b0, 32'h08, 16'd0, 32'd0);
        idle(); drain();

        // stall: response held, requests blocked
        ready_mode = 2;
        @(negedge clk);
        send(1'b1, 2'd2, 1'b0, 32'h08, 16'd0, 32'h0000_00A5);
        idle();
        for (int k = 0; k < 3; k++) begin
            #4;
            chk($sformatf("stall_ready_%0d", k), {33'd0, rdy0}, 34'd0);
            @(negedge clk);
        end
        ready_mode = 0;
        @(negedge clk);
        c0 = cyc;
        send(1'b1, 2'd2, 1'b0, 32'h00, 16'd0, 32'd5);
        send(1'b0, 2'd2, 1'b0, 32'h00, 16'd0, 32'd0);
        for (int i = 1; i <= 6; i++) send(1'b0, 2'd2, 1'b0, 32'(4*i), 16'd0, 32'd0);
        chk("throughput_cycles", 34'(cyc - c0), 34'd8);
        idle(); drain();

        // randomized traffic with random backpressure
        ready_mode = 1;
        for (int n = 0; n < 250; n++) begin
            int r;
            logic [1:0] sz;
            r  = $urandom_range(0, 15);
            sz = (r == 0) ? 2'd3 : 2'(r % 3);
            send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, NBYTES + 6)), 16'($urandom_range(0, 16)) - 16'd8,
                 $urandom);
            if ($urandom_range(0, 7) == 0) begin idle(); @(negedge clk); end
        end
        idle(); drain();

        // populate the retaining instance
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            keep_data[i] = $urandom;
            send(1'b1, 2'd2, 1'b0, 32'(8*i), 16'd0, keep_data[i]);
        end
        send(1'b0, 2'd2, 1'b0, 32'h08, 16'd0, 32'd0);
        idle(); drain();

        // reset with a pending response, then reset during the sweep
        sel = 1'b0;
        ready_mode = 2;
        @(negedge clk);
        send(1'b0, 2'd2, 1'b0, 32'h00, 16'd0, 32'd0);
        idle();
        #4;
        chk("pending_before_reset", {33'd0, rv0}, 34'd1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("reset_drops_rsp", {33'd0, rv0}, 34'd0);
        @(negedge clk);
        reset = 1'b0;
        ready_mode = 0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sweep_check();
        for (int i = 0; i < DEPTH; i += 3) send(1'b0, 2'd2, 1'b0, 32'(4*i), 16'd0, 32'd0);
        idle(); drain();

        // retaining instance keeps its contents across reset
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) send(1'b0, 2'd2, 1'b0, 32'(8*i), 16'd0, 32'd0);
        send(1'b0, 2'd1, 1'b1, 32'h0A, 16'd0, 32'd0);
        idle(); drain();
        for (int i = 0; i < 6; i++)
            chk($sformatf("keep_model_%0d", i),
                {2'b0, bmem1[8*i+3], bmem1[8*i+2], bmem1[8*i+1], bmem1[8*i]},
                {2'b0, keep_data[i]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
